// File: rtl/sonic_port_link_ctrl_if.sv
// -----------------------------------------------------------------------------
// sonic_port_link_ctrl_if
//   Bundles the status inputs and control outputs of the SoNIC port link
//   sequencer. Clock and reset stay as plain ports on the sequencer.
//
//   Status towards the sequencer (driven by the master side):
//     xcvr_tx_ready, xcvr_rx_ready  transceiver ready flags, asynchronous
//     lock                          blocksync lock, clk_in domain
//     sw_enable                     level, 0 forces IDLE
//     sw_restart                    pulse, leaves FAULT
//     sw_bypass_req                 level, requested clocksync bypass
//     sw_loopback_req               level, requested encoder->decoder loopback
//   Controls from the sequencer (driven by the slave side):
//     ctrl_disable, ctrl_clear, ctrl_bypass  clocksync controls
//     endec_loopback                         encoder/decoder loopback select
//     link_up, fault                         status flags
//     state[2:0], retry_cnt[3:0]             CSR read-back
// -----------------------------------------------------------------------------
interface sonic_port_link_ctrl_if;
    logic       xcvr_tx_ready;
    logic       xcvr_rx_ready;
    logic       lock;
    logic       sw_enable;
    logic       sw_restart;
    logic       sw_bypass_req;
    logic       sw_loopback_req;
    logic       ctrl_disable;
    logic       ctrl_clear;
    logic       ctrl_bypass;
    logic       endec_loopback;
    logic       link_up;
    logic       fault;
    logic [2:0] state;
    logic [3:0] retry_cnt;

    modport master (
        output xcvr_tx_ready, xcvr_rx_ready, lock,
        output sw_enable, sw_restart, sw_bypass_req, sw_loopback_req,
        input  ctrl_disable, ctrl_clear, ctrl_bypass, endec_loopback,
        input  link_up, fault, state, retry_cnt
    );

    modport slave (
        input  xcvr_tx_ready, xcvr_rx_ready, lock,
        input  sw_enable, sw_restart, sw_bypass_req, sw_loopback_req,
        output ctrl_disable, ctrl_clear, ctrl_bypass, endec_loopback,
        output link_up, fault, state, retry_cnt
    );
endinterface

// File: rtl/sonic_port_link_ctrl.sv
// -----------------------------------------------------------------------------
// sonic_port_link_ctrl
//   Link bring-up and recovery sequencer for one SoNIC PHY port (clk_in domain).
//   Waits for the transceivers, waits for a stable blocksync lock, pulses the
//   clocksync clear, then enables clocksync. On link loss it disables clocksync,
//   holds off and retries; after too many retries it parks in FAULT until
//   software restarts it.
//
//   Ports:
//     clk_in    port core clock
//     rst_n_in  asynchronous reset, active low
//     link      sonic_port_link_ctrl_if.slave (status in, controls out)
//
//   Every output is a flop. Output values are computed from the next state so
//   that they change on the same edge as the state register.
// -----------------------------------------------------------------------------
module sonic_port_link_ctrl #(
    parameter logic [31:0] LOCK_TIMEOUT = 32'd1000000,
    parameter logic [15:0] LOCK_STABLE  = 16'd1024,
    parameter logic [15:0] LOSS_CYCLES  = 16'd64,
    parameter logic [7:0]  CLEAR_CYCLES = 8'd16,
    parameter logic [15:0] HOLDOFF      = 16'd4096,
    parameter logic [3:0]  MAX_RETRY    = 4'd8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    sonic_port_link_ctrl_if.slave link
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_XCVR = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_CLEAR     = 3'd3,
        ST_SYNC      = 3'd4,
        ST_RECOVER   = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Transceiver ready synchronisers
    // ------------------------------------------------------------------
    logic r_tx_meta, r_tx_sync;
    logic r_rx_meta, r_rx_sync;

    // NOTE: flops are written with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tx_meta <= 1'b0;
            r_tx_sync <= 1'b0;
            r_rx_meta <= 1'b0;
            r_rx_sync <= 1'b0;
        end else begin
            r_tx_meta <= link.xcvr_tx_ready;
            r_tx_sync <= r_tx_meta;
            r_rx_meta <= link.xcvr_rx_ready;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_lock_tmr;
    logic [15:0] r_stable;
    logic [7:0]  r_clr;
    logic [15:0] r_loss;
    logic [15:0] r_hold;
    logic [3:0]  r_retry;
    logic        r_loopback;
    logic        r_ctrl_disable;
    logic        r_ctrl_clear;
    logic        r_ctrl_bypass;
    logic        r_link_up;
    logic        r_fault;

    // Saturating increments: no timer ever wraps back to a small value.
    logic [31:0] w_lock_tmr_inc;
    logic [15:0] w_stable_inc;
    logic [7:0]  w_clr_inc;
    logic [15:0] w_loss_inc;
    logic [15:0] w_hold_inc;
    logic [3:0]  w_retry_inc;

    assign w_lock_tmr_inc = (r_lock_tmr == '1) ? r_lock_tmr : r_lock_tmr + 32'd1;
    assign w_stable_inc   = (r_stable   == '1) ? r_stable   : r_stable   + 16'd1;
    assign w_clr_inc      = (r_clr      == '1) ? r_clr      : r_clr      + 8'd1;
    assign w_loss_inc     = (r_loss     == '1) ? r_loss     : r_loss     + 16'd1;
    assign w_hold_inc     = (r_hold     == '1) ? r_hold     : r_hold     + 16'd1;
    assign w_retry_inc    = (r_retry    == '1) ? r_retry    : r_retry    + 4'd1;

    // In loopback the decoder sees our own encoder, so RX readiness is moot.
    logic w_link_ok;
    logic w_xcvr_ok;

    assign w_link_ok = link.lock && (r_rx_sync || r_loopback);
    assign w_xcvr_ok = r_tx_sync && (r_rx_sync || r_loopback);

    // NOTE: w_next takes a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                w_next = ST_WAIT_XCVR;
            end
            ST_WAIT_XCVR: begin
                if (w_xcvr_ok) w_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Stable lock is checked before the timeout so it wins a tie.
                if (!r_tx_sync)
                    w_next = ST_RECOVER;
                else if (w_link_ok && (w_stable_inc >= LOCK_STABLE))
                    w_next = ST_CLEAR;
                else if (w_lock_tmr_inc >= LOCK_TIMEOUT)
                    w_next = ST_RECOVER;
            end
            ST_CLEAR: begin
                if (!r_tx_sync)
                    w_next = ST_RECOVER;
                else if (w_clr_inc >= CLEAR_CYCLES)
                    w_next = ST_SYNC;
            end
            ST_SYNC: begin
                // TX loss is fatal at once; RX/lock loss is debounced.
                if (!r_tx_sync)
                    w_next = ST_RECOVER;
                else if (!w_link_ok && (w_loss_inc >= LOSS_CYCLES))
                    w_next = ST_RECOVER;
            end
            ST_RECOVER: begin
                // r_retry already holds the incremented count taken on entry.
                if (r_retry > MAX_RETRY)
                    w_next = ST_FAULT;
                else if (w_hold_inc >= HOLDOFF)
                    w_next = ST_WAIT_XCVR;
            end
            ST_FAULT: begin
                if (link.sw_restart) w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        // Software disable overrides every other transition.
        if (!link.sw_enable) w_next = ST_IDLE;
    end

    // Each counter runs only while its state is held, so every entry into a
    // state starts its counter from zero.
    logic w_stay_lock, w_stay_clear, w_stay_sync, w_stay_recover;

    assign w_stay_lock    = (r_state == ST_WAIT_LOCK) && (w_next == ST_WAIT_LOCK);
    assign w_stay_clear   = (r_state == ST_CLEAR)     && (w_next == ST_CLEAR);
    assign w_stay_sync    = (r_state == ST_SYNC)      && (w_next == ST_SYNC);
    assign w_stay_recover = (r_state == ST_RECOVER)   && (w_next == ST_RECOVER);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state        <= ST_IDLE;
            r_lock_tmr     <= '0;
            r_stable       <= '0;
            r_clr          <= '0;
            r_loss         <= '0;
            r_hold         <= '0;
            r_retry        <= '0;
            r_loopback     <= 1'b0;
            r_ctrl_disable <= 1'b1;
            r_ctrl_clear   <= 1'b0;
            r_ctrl_bypass  <= 1'b1;
            r_link_up      <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            r_state <= w_next;

            r_lock_tmr <= w_stay_lock ? w_lock_tmr_inc : '0;
            r_stable   <= (w_stay_lock && w_link_ok) ? w_stable_inc : '0;
            r_clr      <= w_stay_clear ? w_clr_inc : '0;
            r_loss     <= (w_stay_sync && !w_link_ok) ? w_loss_inc : '0;
            r_hold     <= w_stay_recover ? w_hold_inc : '0;

            if (w_next == ST_IDLE)
                r_retry <= '0;
            else if ((w_next == ST_RECOVER) && (r_state != ST_RECOVER))
                r_retry <= w_retry_inc;

            // Loopback is chosen once per bring-up and then frozen.
            if ((r_state == ST_IDLE) && (w_next == ST_WAIT_XCVR))
                r_loopback <= link.sw_loopback_req;

            r_ctrl_disable <= (w_next != ST_SYNC);
            r_ctrl_clear   <= (w_next == ST_CLEAR);
            r_ctrl_bypass  <= (w_next == ST_SYNC) ? link.sw_bypass_req : 1'b1;
            r_link_up      <= (w_next == ST_SYNC);
            r_fault        <= (w_next == ST_FAULT);
        end
    end

    assign link.ctrl_disable   = r_ctrl_disable;
    assign link.ctrl_clear     = r_ctrl_clear;
    assign link.ctrl_bypass    = r_ctrl_bypass;
    assign link.endec_loopback = r_loopback;
    assign link.link_up        = r_link_up;
    assign link.fault          = r_fault;
    assign link.state          = r_state;
    assign link.retry_cnt      = r_retry;

endmodule

// File: tb/tb_sonic_port_link_ctrl.sv
module tb_sonic_port_link_ctrl;

  localparam int P_LOCK_TIMEOUT = 120;
  localparam int P_LOCK_STABLE  = 24;
  localparam int P_LOSS_CYCLES  = 64;
  localparam int P_CLEAR_CYCLES = 16;
  localparam int P_HOLDOFF      = 20;
  localparam int P_MAX_RETRY    = 2;

  localparam int S_IDLE = 0, S_WAIT_XCVR = 1, S_WAIT_LOCK = 2, S_CLEAR = 3,
                 S_SYNC = 4, S_RECOVER = 5, S_FAULT = 6;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sonic_port_link_ctrl_if u_if ();

  sonic_port_link_ctrl #(
    .LOCK_TIMEOUT (32'(P_LOCK_TIMEOUT)),
    .LOCK_STABLE  (16'(P_LOCK_STABLE)),
    .LOSS_CYCLES  (16'(P_LOSS_CYCLES)),
    .CLEAR_CYCLES (8'(P_CLEAR_CYCLES)),
    .HOLDOFF      (16'(P_HOLDOFF)),
    .MAX_RETRY    (4'(P_MAX_RETRY))
  ) u_dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .link     (u_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one step per clock edge, written from the behavioural
  // rules. q1/q2 stand for the two synchroniser stages.
  int m_st, m_retry, m_run, m_tmr, m_bad, m_age;
  bit m_loop, m_bypass;
  bit m_tx_q1, m_tx_q2, m_rx_q1, m_rx_q2;

  task automatic model_reset();
    m_st = S_IDLE; m_retry = 0; m_run = 0; m_tmr = 0; m_bad = 0; m_age = 0;
    m_loop = 1'b0; m_bypass = 1'b1;
    m_tx_q1 = 1'b0; m_tx_q2 = 1'b0; m_rx_q1 = 1'b0; m_rx_q2 = 1'b0;
  endtask

  task automatic model_step();
    int nxt;
    bit tx_s, rx_s, ok;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tx_s = m_tx_q2;
    rx_s = m_rx_q2;
    m_tx_q2 = m_tx_q1; m_rx_q2 = m_rx_q1;
    m_tx_q1 = u_if.xcvr_tx_ready; m_rx_q1 = u_if.xcvr_rx_ready;
    ok  = u_if.lock && (rx_s || m_loop);
    nxt = m_st;
    case (m_st)
      S_IDLE:      nxt = S_WAIT_XCVR;
      S_WAIT_XCVR: if (tx_s && (rx_s || m_loop)) nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        m_run = ok ? m_run + 1 : 0;
        m_tmr = m_tmr + 1;
        if (!tx_s) nxt = S_RECOVER;
        else if (m_run >= P_LOCK_STABLE) nxt = S_CLEAR;
        else if (m_tmr >= P_LOCK_TIMEOUT) nxt = S_RECOVER;
      end
      S_CLEAR: begin
        m_age = m_age + 1;
        if (!tx_s) nxt = S_RECOVER;
        else if (m_age >= P_CLEAR_CYCLES) nxt = S_SYNC;
      end
      S_SYNC: begin
        m_bad = ok ? 0 : m_bad + 1;
        if (!tx_s) nxt = S_RECOVER;
        else if (m_bad >= P_LOSS_CYCLES) nxt = S_RECOVER;
      end
      S_RECOVER: begin
        m_age = m_age + 1;
        if (m_retry > P_MAX_RETRY) nxt = S_FAULT;
        else if (m_age >= P_HOLDOFF) nxt = S_WAIT_XCVR;
      end
      S_FAULT: if (u_if.sw_restart) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (!u_if.sw_enable) nxt = S_IDLE;
    if (m_st == S_IDLE && nxt == S_WAIT_XCVR) m_loop = u_if.sw_loopback_req;
    if (nxt != m_st) begin
      m_run = 0; m_tmr = 0; m_bad = 0; m_age = 0;
    end
    if (nxt == S_RECOVER && m_st != S_RECOVER) m_retry = (m_retry < 15) ? m_retry + 1 : 15;
    if (nxt == S_IDLE) m_retry = 0;
    m_bypass = (nxt == S_SYNC) ? u_if.sw_bypass_req : 1'b1;
    m_st = nxt;
  endtask

  function automatic logic [13:0] model_outs();
    logic [2:0] st;
    logic [3:0] rc;
    st = 3'(m_st);
    rc = 4'(m_retry);
    return {st, rc, (m_st != S_SYNC), (m_st == S_CLEAR), m_bypass, m_loop,
            (m_st == S_SYNC), (m_st == S_FAULT)};
  endfunction

  function automatic logic [13:0] dut_outs();
    return {u_if.state, u_if.retry_cnt, u_if.ctrl_disable, u_if.ctrl_clear,
            u_if.ctrl_bypass, u_if.endec_loopback, u_if.link_up, u_if.fault};
  endfunction

  // One clock: model steps on the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model", 32'(dut_outs()), 32'(model_outs()));
  endtask

  task automatic wait_state(input int target, input int budget, input string tag);
    int n = 0;
    while (u_if.state != 3'(target) && n < budget) begin
      cycle();
      n++;
    end
    check(tag, 32'(u_if.state), 32'(target));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_disable"},  32'(u_if.ctrl_disable),   32'd1);
    check({tag, "_bypass"},   32'(u_if.ctrl_bypass),    32'd1);
    check({tag, "_loopback"}, 32'(u_if.endec_loopback), 32'd0);
    check({tag, "_clear"},    32'(u_if.ctrl_clear),     32'd0);
    check({tag, "_link_up"},  32'(u_if.link_up),        32'd0);
    check({tag, "_fault"},    32'(u_if.fault),          32'd0);
    check({tag, "_state"},    32'(u_if.state),          32'd0);
    check({tag, "_retry"},    32'(u_if.retry_cnt),      32'd0);
  endtask

  initial begin
    int clr_cnt, first_clr, n;

    rst_n = 1'b0;
    u_if.xcvr_tx_ready = 1'b0; u_if.xcvr_rx_ready = 1'b0; u_if.lock = 1'b0;
    u_if.sw_enable = 1'b0; u_if.sw_restart = 1'b0;
    u_if.sw_bypass_req = 1'b0; u_if.sw_loopback_req = 1'b0;
    model_reset();
    repeat (3) cycle();
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) cycle();

    // T1 bring-up
    u_if.sw_enable = 1'b1;
    repeat (10) cycle();
    u_if.xcvr_tx_ready = 1'b1; u_if.xcvr_rx_ready = 1'b1;
    repeat (10) cycle();
    u_if.lock = 1'b1;
    clr_cnt = 0; first_clr = -1; n = 0;
    while (!u_if.link_up && n < 200) begin
      cycle();
      n++;
      if (u_if.ctrl_clear) begin
        if (first_clr < 0) first_clr = n;
        clr_cnt++;
      end
    end
    check("t1_clear_start", 32'(first_clr >= P_LOCK_STABLE && first_clr <= P_LOCK_STABLE + 3), 32'd1);
    check("t1_clear_len", 32'(clr_cnt), 32'(P_CLEAR_CYCLES));
    check("t1_link_up", 32'(u_if.link_up), 32'd1);
    check("t1_disable", 32'(u_if.ctrl_disable), 32'd0);

    // T2 glitch filter
    u_if.lock = 1'b0;
    repeat (P_LOSS_CYCLES - 1) cycle();
    u_if.lock = 1'b1;
    cycle();
    check("t2_short_drop", 32'(u_if.state), 32'(S_SYNC));
    u_if.lock = 1'b0;
    repeat (P_LOSS_CYCLES) cycle();
    check("t2_long_drop", 32'(u_if.state), 32'(S_RECOVER));
    check("t2_retry", 32'(u_if.retry_cnt), 32'd1);
    check("t2_disable", 32'(u_if.ctrl_disable), 32'd1);
    u_if.lock = 1'b1;
    wait_state(S_SYNC, 200, "t2_resync");

    // T5 bypass
    u_if.sw_bypass_req = 1'b1;
    cycle();
    check("t5_bypass_on", 32'(u_if.ctrl_bypass), 32'd1);
    u_if.sw_bypass_req = 1'b0;
    cycle();
    check("t5_bypass_off", 32'(u_if.ctrl_bypass), 32'd0);
    u_if.xcvr_tx_ready = 1'b0;
    wait_state(S_RECOVER, 10, "t5_tx_loss");
    check("t5_forced_bypass", 32'(u_if.ctrl_bypass), 32'd1);
    check("t5_retry", 32'(u_if.retry_cnt), 32'd2);
    u_if.xcvr_tx_ready = 1'b1;
    wait_state(S_SYNC, 200, "t5_resync");

    // T6 disable from SYNC
    u_if.sw_enable = 1'b0;
    cycle();
    check("t6_disable_idle", 32'(u_if.state), 32'(S_IDLE));
    check("t6_disable_retry", 32'(u_if.retry_cnt), 32'd0);

    // T3 lock timeout until FAULT
    u_if.lock = 1'b0;
    u_if.sw_enable = 1'b1;
    wait_state(S_FAULT, 1500, "t3_fault_state");
    check("t3_fault", 32'(u_if.fault), 32'd1);
    check("t3_retry", 32'(u_if.retry_cnt), 32'(P_MAX_RETRY + 1));
    u_if.sw_restart = 1'b1;
    cycle();
    u_if.sw_restart = 1'b0;
    check("t3_restart_idle", 32'(u_if.state), 32'(S_IDLE));
    check("t3_restart_retry", 32'(u_if.retry_cnt), 32'd0);

    // T4 loopback
    u_if.sw_enable = 1'b0;
    cycle();
    u_if.xcvr_rx_ready = 1'b0; u_if.sw_loopback_req = 1'b1; u_if.lock = 1'b1;
    u_if.sw_enable = 1'b1;
    wait_state(S_SYNC, 200, "t4_sync");
    check("t4_loopback", 32'(u_if.endec_loopback), 32'd1);
    u_if.sw_loopback_req = 1'b0;
    repeat (10) cycle();
    check("t4_frozen", 32'(u_if.endec_loopback), 32'd1);
    check("t4_still_sync", 32'(u_if.state), 32'(S_SYNC));
    u_if.xcvr_rx_ready = 1'b1;

    // T6 async reset during CLEAR
    u_if.sw_enable = 1'b0;
    cycle();
    u_if.sw_enable = 1'b1;
    wait_state(S_CLEAR, 200, "t6_reach_clear");
    #2 rst_n = 1'b0;
    #1 check_reset_values("t6_async");
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
    wait_state(S_SYNC, 200, "t6_after_reset");

    // Randomised stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0)  u_if.lock = ~u_if.lock;
      if ($urandom_range(0, 299) == 0) u_if.xcvr_tx_ready = ~u_if.xcvr_tx_ready;
      if ($urandom_range(0, 299) == 0) u_if.xcvr_rx_ready = ~u_if.xcvr_rx_ready;
      if ($urandom_range(0, 499) == 0) u_if.sw_enable = ~u_if.sw_enable;
      if ($urandom_range(0, 19) == 0)  u_if.sw_bypass_req = ~u_if.sw_bypass_req;
      if ($urandom_range(0, 29) == 0)  u_if.sw_loopback_req = ~u_if.sw_loopback_req;
      u_if.sw_restart = ($urandom_range(0, 49) == 0);
      if (!u_if.xcvr_tx_ready && $urandom_range(0, 19) == 0) u_if.xcvr_tx_ready = 1'b1;
      if (!u_if.sw_enable && $urandom_range(0, 9) == 0) u_if.sw_enable = 1'b1;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
